// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: decodes I/S/B/U/J/R immediates into an elastic result FIFO.
// Optional macro IMM_GEN_ZIMM_EN adds CSR*I zero-extended zimm decode (fmt=6).
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  instruction,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [XLEN-1:0]       imm,
    output logic [2:0]                   fmt,
    output logic                         unsupported,
    output logic [$clog2(DEPTH):0]       level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;
`ifdef IMM_GEN_ZIMM_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    typedef struct packed {
        logic signed [XLEN-1:0] imm;
        logic [2:0]             fmt;
        logic                   unsup;
    } entry_t;

    // Every format is first assembled as a signed 32-bit value so that the
    // final widening to XLEN replicates inst[31] in one place.
    function automatic entry_t decode(input logic [31:0] inst);
        entry_t            e;
        logic signed [31:0] v;
        v       = '0;
        e.fmt   = FMT_NONE;
        e.unsup = 1'b0;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                v     = {{20{inst[31]}}, inst[31:20]};
                e.fmt = FMT_I;
            end
            7'b0100011: begin
                v     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                e.fmt = FMT_S;
            end
            7'b1100011: begin
                v     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                e.fmt = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                v     = {inst[31:12], 12'b0};
                e.fmt = FMT_U;
            end
            7'b1101111: begin
                v     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                e.fmt = FMT_J;
            end
            7'b0110011, 7'b0111011: begin
                e.fmt = FMT_R;
            end
`ifdef IMM_GEN_ZIMM_EN
            7'b1110011: begin
                if (inst[14] && (inst[13:12] != 2'b00)) begin
                    v     = {27'b0, inst[19:15]};
                    e.fmt = FMT_Z;
                end else begin
                    e.unsup = 1'b1;
                end
            end
`endif
            default: begin
                e.unsup = 1'b1;
            end
        endcase
        e.imm = XLEN'(v);
        return e;
    endfunction

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    entry_t          dec_p0;
    logic            push;
    logic            pop;

    // Stage p0: combinational decode feeding the FIFO write port
    assign dec_p0    = decode(instruction);
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec_p0;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Stage p1: head entry drives the outputs
    assign imm         = mem[rd_ptr].imm;
    assign fmt         = mem[rd_ptr].fmt;
    assign unsupported = mem[rd_ptr].unsup;
    assign level       = count;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=64, DEPTH=2).
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic              out_valid;
    logic              out_ready;
    logic signed [XLEN-1:0] imm;
    logic [2:0]        fmt;
    logic              unsupported;
    logic [$clog2(DEPTH):0] level;

    int total  = 0;
    int passed = 0;

    imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .fmt(fmt), .unsupported(unsupported), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] inst);
        in_valid    = 1'b1;
        instruction = inst;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [63:0] e_imm,
                            input logic [2:0] e_fmt, input logic e_uns);
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_imm"}, imm, e_imm);
        chk({tag, "_fmt"}, 64'(fmt), 64'(e_fmt));
        chk({tag, "_uns"}, 64'(unsupported), 64'(e_uns));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = '0;
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", imm, 64'd0);
        chk("rst_fmt", 64'(fmt), 64'd0);
        chk("rst_uns", 64'(unsupported), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        rst_n = 1'b1;
        tick();

        // Format decode, one per cycle with consumer ready
        out_ready = 1'b1;
        push_one(32'h00500093); chk_head("i_pos", 64'h5, 3'd1, 1'b0);
        chk("lat_level", 64'(level), 64'd1);
        push_one(32'hfff00093); chk_head("i_neg", 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        push_one(32'hfe000ce3); chk_head("b_neg", 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
        push_one(32'h00113423); chk_head("s_pos", 64'h8, 3'd2, 1'b0);
        push_one(32'h123450b7); chk_head("u", 64'h0000000012345000, 3'd4, 1'b0);
        push_one(32'h0080006f); chk_head("j", 64'h8, 3'd5, 1'b0);
        push_one(32'h00208033); chk_head("r", 64'h0, 3'd0, 1'b0);
        push_one(32'h0000007f); chk_head("bad", 64'h0, 3'd7, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
        push_one(32'h3401d0f3); chk_head("zimm", 64'h3, 3'd6, 1'b0);
`else
        push_one(32'h3401d0f3); chk_head("sys", 64'h0, 3'd7, 1'b1);
`endif
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("empty_pop_level", 64'(level), 64'd0);

        // Fill with consumer stalled, then drain in order
        out_ready = 1'b0;
        push_one(32'h00100093);
        push_one(32'h00200093);
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", imm, 64'h1);
        push_one(32'h00300093);
        chk("blocked_level", 64'(level), 64'(DEPTH));
        chk("stall_head", imm, 64'h1);
        out_ready = 1'b1;
        tick();
        chk("drain1_imm", imm, 64'h2);
        chk("drain1_level", 64'(level), 64'd1);
        chk("drain1_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("drain2_valid", 64'(out_valid), 64'd0);

        // Back-to-back stream across several pointer wraps
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            push_one({12'(i + 10), 20'h00093});
            chk($sformatf("stream%0d_imm", i), imm, 64'(i + 10));
            chk($sformatf("stream%0d_level", i), 64'(level), 64'd1);
        end
        tick();
        chk("stream_end_level", 64'(level), 64'd0);

        // Flush with a simultaneous push drops everything
        out_ready = 1'b0;
        push_one(32'h00100093);
        push_one(32'h00200093);
        in_valid = 1'b1; flush = 1'b1; instruction = 32'h00300093;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset between clock edges
        push_one(32'h00700093);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_level", 64'(level), 64'd0);
        chk("async_rst_imm", imm, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. It accepts 32-bit RV instructions over a valid/ready handshake and decodes every base immediate format (I/S/B/U/J) plus R, sign-extended to XLEN. Results, with a format code and an unsupported flag, are stored in a DEPTH-entry elastic FIFO. It sits between fetch/IF-ID and the decode/register-read stage and absorbs stalls from downstream.

Parameters:
XLEN, 64, immediate output width; legal values are 32 and 64.
DEPTH, 2, output FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all buffered entries
in_valid  input  1  instruction present
in_ready  output  1  block can accept
instruction  input  32  raw instruction word
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
imm  output  XLEN  sign-extended immediate of head entry
fmt  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (optional), 7=NONE
unsupported  output  1  opcode not decoded
level  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: count=0, read/write pointers=0, all storage=0. Outputs are out_valid=0, in_ready=1, imm=0, fmt=0, unsupported=0, level=0.
- Decode on opcode inst[6:0]:
  - I: 0000011, 0010011, 0011011, 1100111. imm = sext(inst[31:20]).
  - S: 0100011. imm = sext({inst[31:25],inst[11:7]}).
  - B: 1100011. imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U: 0110111, 0010111. imm = sext({inst[31:12],12'b0}).
  - J: 1101111. imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - R: 0110011, 0111011. imm=0, fmt=0.
  - Any other opcode: imm=0, fmt=7, unsupported=1. The entry is still enqueued.
- Sign extension always replicates inst[31] up to XLEN-1.
- Handshake:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (count != DEPTH). No combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
  - imm/fmt/unsupported are driven from the head entry and stay stable while out_valid && !out_ready.
- Latency: with the FIFO empty, an instruction pushed at edge N gives out_valid=1 with its result after edge N, i.e. one cycle.
- Throughput: with DEPTH>=2 and out_ready held high, one instruction per cycle.
- Boundary conditions:
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
  - Full: in_ready=0. A pop on that cycle frees the slot visible next cycle. No push occurs the same cycle.
  - Empty: a pop request is ignored (out_valid=0).
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count saturates naturally because in_ready blocks the push that would overflow.
  - flush: next edge sets count=0 and pointers=0. Flush wins over a push or pop on the same cycle, so the pushed instruction is dropped. Storage contents need not clear, but out_valid=0.
  - rst_n asserted mid-transfer: immediately returns to reset values. In-flight entries are lost.
- level = count.

Optional Feature:
IMM_GEN_ZIMM_EN.
- Defined: SYSTEM opcode 1110011 with funct3 in {101,110,111} (CSRRWI/CSRRSI/CSRRCI) gives fmt=6, imm = zero-extended inst[19:15], unsupported=0. Other SYSTEM funct3 values give fmt=7, unsupported=1.
- Undefined: all SYSTEM encodings give fmt=7, imm=0, unsupported=1.

Test Plan:
- Reset, then push 32'h00500093 with out_ready=1 -> next cycle out_valid=1, imm=64'h5, fmt=1. Then push 32'hfff00093 -> imm=64'hFFFFFFFFFFFFFFFF.
- Push 32'hfe000ce3 -> imm=64'hFFFFFFFFFFFFFFF8, fmt=3. Push 32'h00113423 -> imm=64'h8, fmt=2. Push 32'h123450b7 -> imm=64'h0000000012345000, fmt=4. With XLEN=32, 32'hfff00093 -> imm=32'hFFFFFFFF.
- out_ready=0, push DEPTH instructions -> level=DEPTH, in_ready=0, and head imm stays stable. Then release out_ready -> results drain in order, one per cycle.
- Continuous push with out_ready=1 for 2*DEPTH+3 cycles -> no bubbles, pointers wrap, order preserved, level never exceeds 1.
- Push 32'h0000007f -> fmt=7, unsupported=1, imm=0. Fill the FIFO, assert flush together with in_valid -> next cycle level=0 and out_valid=0.
- With IMM_GEN_ZIMM_EN defined, push 32'h3401d0f3 (csrrwi, zimm=3) -> fmt=6, imm=64'h3. Without the macro -> fmt=7, unsupported=1. Assert rst_n=0 mid-stream -> out_valid falls immediately.
